branch_sequencer: RTL and testbench

- Multicycle fetch/sequence controller for the miniRISC core. It owns the PC, fetches instructions over a req/ack memory handshake, and hands each instruction to the datapath.
- It holds the processor status flags (sign, zero, carry). It evaluates branch conditions for opcodes 001000–001111 and selects the next PC.
- It sits between instruction memory and the execute datapath and replaces free-running PC logic.

---
 rtl/miniRISC_pkg.sv | 30 +++
 rtl/branch_cond.sv | 25 ++
 rtl/branch_sequencer.sv | 131 +++++++++++++
 tb/tb_branch_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/miniRISC_pkg.sv
// Shared definitions for the miniRISC fetch/sequence controller: opcodes,
// sequencer states and the PC stride.
package miniRISC_pkg;

    localparam logic [5:0] OP_BR   = 6'b001000;
    localparam logic [5:0] OP_BR2  = 6'b001001;
    localparam logic [5:0] OP_BLT  = 6'b001010;
    localparam logic [5:0] OP_BZ   = 6'b001011;
    localparam logic [5:0] OP_BNZ  = 6'b001100;
    localparam logic [5:0] OP_JAL  = 6'b001101;
    localparam logic [5:0] OP_BC   = 6'b001110;
    localparam logic [5:0] OP_BNZ2 = 6'b001111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // The whole 001xxx group is treated as branches, so flag writes are suppressed for them.
    function automatic logic is_branch(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides whether the current opcode redirects
// the PC, given the registered status flags.
module branch_cond
    import miniRISC_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       sign,
    input  logic       zero,
    input  logic       carry,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BR, OP_BR2, OP_JAL: taken = 1'b1;
            OP_BLT:                taken = sign & ~zero;
            OP_BZ:                 taken = zero;
            OP_BNZ, OP_BNZ2:       taken = ~zero;
            OP_BC:                 taken = carry;
            default:               taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multicycle fetch/decode/execute/update sequencer for the miniRISC core.
// Owns the PC and status flags and resolves branches in the UPDATE cycle.
module branch_sequencer
    import miniRISC_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              flag_we,
    input  logic              sign_in,
    input  logic              zero_in,
    input  logic              carry_in,
    input  logic [PC_W-1:0]   br_target,
    output logic              link_we,
    output logic [PC_W-1:0]   link_pc,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INST_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]     br_tgt_q, br_tgt_d;
    logic [PC_W-1:0]     link_pc_q, link_pc_d;
    logic                sign_q, sign_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic                halted_q, halted_d;
    // Low for the single cycle after reset so the request drops even though the state is FETCH.
    logic                req_en_q, req_en_d;
    logic                taken;
    logic [5:0]          opcode;
    logic [PC_W-1:0]     pc_plus4;

    assign opcode   = instr_q[INST_W-1 -: 6];
    assign pc_plus4 = pc_q + PC_W'(PC_INC);

    branch_cond u_branch_cond (
        .opcode (opcode),
        .sign   (sign_q),
        .zero   (zero_q),
        .carry  (carry_q),
        .taken  (taken)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        br_tgt_d  = br_tgt_q;
        link_pc_d = link_pc_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        req_en_d  = 1'b1;
        case (state_q)
            ST_FETCH: begin
                if (imem_req && imem_ack) begin
                    instr_d = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (flag_we && !is_branch(opcode)) begin
                    sign_d  = sign_in;
                    zero_d  = zero_in;
                    carry_d = carry_in;
                end
                if (exec_done) begin
                    br_tgt_d  = br_target;
                    link_pc_d = pc_plus4;
                    state_d   = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                pc_d    = taken ? (br_tgt_q & ~PC_W'(3)) : pc_plus4;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            br_tgt_q  <= '0;
            link_pc_q <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            halted_q  <= 1'b0;
            req_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            br_tgt_q  <= br_tgt_d;
            link_pc_q <= link_pc_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            halted_q  <= halted_d;
            req_en_q  <= req_en_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH) && req_en_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_DECODE);
    assign link_we     = (state_q == ST_UPDATE) && (opcode == OP_JAL);
    assign link_pc     = link_pc_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed table, randomized run
// against a behavioural model, and reset/halt corner sequences.
module tb_branch_sequencer;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack = 1'b0;
    logic [INST_W-1:0] imem_data = '0;
    logic [INST_W-1:0] instr;
    logic              instr_valid;
    logic              exec_done = 1'b0;
    logic              flag_we = 1'b0;
    logic              sign_in = 1'b0;
    logic              zero_in = 1'b0;
    logic              carry_in = 1'b0;
    logic [PC_W-1:0]   br_target = '0;
    logic              link_we;
    logic [PC_W-1:0]   link_pc;
    logic [PC_W-1:0]   pc;
    logic              halted;

    always #5 clk = ~clk;

    branch_sequencer #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
        .flag_we(flag_we), .sign_in(sign_in), .zero_in(zero_in), .carry_in(carry_in),
        .br_target(br_target), .link_we(link_we), .link_pc(link_pc), .pc(pc), .halted(halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: architectural PC and flags only.
    logic [31:0] m_pc;
    bit          m_s, m_z, m_c;

    typedef struct {
        logic [5:0]  op;
        int          ack_dly;
        int          exec_dly;
        bit          fwe;
        bit          s;
        bit          z;
        bit          c;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flag writes outside EXEC must be ignored, so drive junk on them.
    task automatic noise();
        flag_we  = 1'($urandom_range(0, 1));
        sign_in  = 1'($urandom_range(0, 1));
        zero_in  = 1'($urandom_range(0, 1));
        carry_in = 1'($urandom_range(0, 1));
    endtask

    function automatic bit spec_taken(input logic [5:0] op, input bit s, input bit z, input bit c);
        if (op == 6'd8 || op == 6'd9 || op == 6'd13) return 1'b1;
        if (op == 6'd10) return s && !z;
        if (op == 6'd11) return z;
        if (op == 6'd12 || op == 6'd15) return !z;
        if (op == 6'd14) return c;
        return 1'b0;
    endfunction

    task automatic wait_req();
        int k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("imem_req_timeout", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_ack = 1'b0;
        exec_done = 1'b0;
        step();
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_link_we", {31'b0, link_we}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        rst = 1'b1;
        m_pc = 32'h0;
        m_s = 1'b0; m_z = 1'b0; m_c = 1'b0;
    endtask

    task automatic do_instr(input logic [5:0] op, input int ack_dly, input int exec_dly,
                            input bit fwe, input bit s, input bit z, input bit c,
                            input logic [31:0] tgt, input logic [31:0] exp_pc, input bit use_exp);
        logic [31:0] data;
        logic [31:0] pred;
        wait_req();
        for (int i = 0; i < ack_dly; i++) begin
            noise();
            step();
        end
        check("imem_req_held", {31'b0, imem_req}, 32'd1);
        check("imem_addr", imem_addr, m_pc);
        data = {op, 26'($urandom)};
        imem_ack = 1'b1;
        imem_data = data;
        noise();
        step();
        imem_ack = 1'b0;
        imem_data = $urandom;
        check("instr_valid", {31'b0, instr_valid}, 32'd1);
        check("instr", instr, data);
        if (op == 6'b111111) begin
            noise();
            step();
            flag_we = 1'b0;
            check("halted", {31'b0, halted}, 32'd1);
            check("halt_no_req", {31'b0, imem_req}, 32'd0);
            $display("instr op=%b pc=%h -> halted", op, m_pc);
            return;
        end
        noise();
        step();
        check("instr_valid_pulse", {31'b0, instr_valid}, 32'd0);
        flag_we = fwe; sign_in = s; zero_in = z; carry_in = c;
        br_target = $urandom;
        for (int i = 0; i < exec_dly; i++) step();
        exec_done = 1'b1;
        br_target = tgt;
        step();
        exec_done = 1'b0;
        flag_we = 1'b0;
        br_target = $urandom;
        if (fwe && !(op >= 6'd8 && op <= 6'd15)) begin
            m_s = s; m_z = z; m_c = c;
        end
        pred = spec_taken(op, m_s, m_z, m_c) ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
        if (use_exp) pred = exp_pc;
        check("link_we", {31'b0, link_we}, {31'b0, op == 6'b001101});
        if (op == 6'b001101) check("link_pc", link_pc, m_pc + 32'd4);
        noise();
        step();
        flag_we = 1'b0;
        check("pc", pc, pred);
        check("link_we_pulse", {31'b0, link_we}, 32'd0);
        $display("instr op=%b pc=%h tgt=%h -> pc=%h", op, m_pc, tgt, pc);
        m_pc = pred;
    endtask

    initial begin
        logic [5:0] op;
        tbl[0]  = '{6'b000000, 2, 0, 1, 0, 1, 0, 32'h0,        32'h4};
        tbl[1]  = '{6'b001011, 0, 1, 0, 0, 0, 0, 32'h40,       32'h40};
        tbl[2]  = '{6'b000001, 1, 0, 1, 0, 0, 0, 32'h0,        32'h44};
        tbl[3]  = '{6'b001011, 0, 0, 0, 0, 0, 0, 32'h80,       32'h48};
        tbl[4]  = '{6'b000010, 0, 2, 1, 1, 0, 0, 32'h0,        32'h4C};
        tbl[5]  = '{6'b001010, 0, 0, 0, 0, 0, 0, 32'h103,      32'h100};
        tbl[6]  = '{6'b000011, 0, 0, 1, 1, 1, 0, 32'h0,        32'h104};
        tbl[7]  = '{6'b001010, 3, 0, 0, 0, 0, 0, 32'h203,      32'h108};
        tbl[8]  = '{6'b001000, 0, 0, 0, 0, 0, 0, 32'h20,       32'h20};
        tbl[9]  = '{6'b001101, 0, 1, 0, 0, 0, 0, 32'h80,       32'h80};
        tbl[10] = '{6'b000100, 0, 0, 1, 0, 0, 0, 32'h0,        32'h84};
        tbl[11] = '{6'b001110, 0, 1, 1, 0, 0, 1, 32'h200,      32'h88};
        tbl[12] = '{6'b001100, 0, 0, 0, 0, 0, 0, 32'h300,      32'h300};
        tbl[13] = '{6'b001111, 0, 0, 0, 0, 0, 0, 32'h401,      32'h400};
        tbl[14] = '{6'b001001, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFC};
        tbl[15] = '{6'b000101, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0};
        tbl[16] = '{6'b001101, 0, 0, 0, 0, 0, 0, 32'h10,       32'h10};

        step();
        do_reset();
        step();
        check("req_after_dead_cycle", {31'b0, imem_req}, 32'd1);

        for (int i = 0; i < 17; i++)
            do_instr(tbl[i].op, tbl[i].ack_dly, tbl[i].exec_dly, tbl[i].fwe,
                     tbl[i].s, tbl[i].z, tbl[i].c, tbl[i].tgt, tbl[i].exp_pc, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                op = 6'(8 + $urandom_range(0, 7));
            end else begin
                op = 6'($urandom_range(0, 62));
                while (op >= 6'd8 && op <= 6'd15) op = 6'($urandom_range(0, 62));
            end
            do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom, 32'h0, 1'b0);
        end

        // Reset in the middle of a fetch, then a late ack that must be dropped.
        do_instr(6'b001000, 0, 0, 0, 0, 0, 0, 32'h500, 32'h0, 1'b0);
        wait_req();
        check("pre_reset_addr", imem_addr, 32'h500);
        do_reset();
        imem_ack = 1'b1;
        imem_data = {6'b111111, 26'h0};
        step();
        imem_ack = 1'b0;
        check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        check("late_ack_instr", instr, 32'h0);
        check("late_ack_req", {31'b0, imem_req}, 32'd1);
        // Flags were cleared by reset: BC not taken, BNZ taken.
        do_instr(6'b001110, 0, 0, 0, 0, 0, 0, 32'h600, 32'h0, 1'b0);
        do_instr(6'b001100, 1, 1, 0, 0, 0, 0, 32'h700, 32'h0, 1'b0);

        do_instr(6'b111111, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            step();
            check("halt_req_low", {31'b0, imem_req}, 32'd0);
            check("halt_held", {31'b0, halted}, 32'd1);
            check("halt_pc_hold", pc, m_pc);
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        do_reset();
        do_instr(6'b000000, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
